// File: rtl/mem_stack_master.sv
// Byte-serial load/store/stack initiator: each word moves as four little-endian byte accesses.
// Define MEM_STACK_CHECK_EN to enable stack overflow/underflow detection.
module mem_stack_master #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned MEM_BYTES   = 1024,
    parameter int unsigned STACK_LIMIT = 768
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [5:0]        opcode,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       address,
    input  logic [31:0]       wdata,
    input  logic [31:0]       pc,
    input  logic [31:0]       rs1,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic [31:0]       ret_addr,
    output logic [31:0]       rs1_inc,
    output logic [ADDR_W-1:0] sp,
    output logic              stack_fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata
);
    // One extra bit so the empty-stack value MEM_BYTES is distinguishable from address 0
    localparam int unsigned SP_W = ADDR_W + 1;

    localparam logic [5:0] OP_LW    = 6'b000101;
    localparam logic [5:0] OP_LWPOI = 6'b000110;
    localparam logic [5:0] OP_SW    = 6'b000111;
    localparam logic [5:0] OP_PUSH  = 6'b001111;
    localparam logic [5:0] OP_POP   = 6'b010000;
    localparam logic [5:0] OP_CALL  = 6'b001101;
    localparam logic [5:0] OP_RET   = 6'b001110;

    typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;
    state_t state, state_n;

    logic [5:0]        op_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       data_q;
    logic [31:0]       rs1_q;
    logic [23:0]       rbuf_q;
    logic [1:0]        idx_q;
    logic              wr_q, skip_q, fault_q, re_d1;
    logic [SP_W-1:0]   sp_q;

    logic legal, is_wr, is_push, is_pop, qual, fault_c, accept, unused_bits;
    logic busy_n, done_n, fault_n, we_n, re_n;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        wd_n;

    // Opcode decode and qualifier selection
    always_comb begin
        legal   = 1'b0;
        is_wr   = 1'b0;
        is_push = 1'b0;
        is_pop  = 1'b0;
        qual    = 1'b1;
        case (opcode)
            OP_LW, OP_LWPOI:  begin legal = 1'b1; qual = mem_read; end
            OP_SW:            begin legal = 1'b1; is_wr = 1'b1; qual = mem_write; end
            OP_PUSH, OP_CALL: begin legal = 1'b1; is_wr = 1'b1; is_push = 1'b1; end
            OP_POP, OP_RET:   begin legal = 1'b1; is_pop = 1'b1; end
            default:          ;
        endcase
    end

`ifdef MEM_STACK_CHECK_EN
    assign fault_c     = (is_push && (sp_q < SP_W'(STACK_LIMIT + 4))) ||
                         (is_pop  && (sp_q >= SP_W'(MEM_BYTES)));
    assign unused_bits = ^address[31:ADDR_W];
`else
    assign fault_c     = 1'b0;
    assign unused_bits = ^{address[31:ADDR_W], STACK_LIMIT};
`endif

    assign accept = (state == IDLE) && start && legal;
    assign sp     = sp_q[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = (!qual || fault_c) ? DONE : XFER;
            XFER:    if (idx_q == 2'd3) state_n = wr_q ? DONE : DRAIN;
            DRAIN:   state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Registered outputs trail the state by one cycle
    always_comb begin
        busy_n  = (state_n != IDLE);
        done_n  = (state == DONE);
        fault_n = (state == DONE) && fault_q;
        we_n    = (state == XFER) && wr_q;
        re_n    = (state == XFER) && !wr_q;
        addr_n  = (state == XFER) ? base_q + ADDR_W'(idx_q) : '0;
        wd_n    = we_n ? 8'(data_q >> {idx_q, 3'b000}) : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= '0;
            base_q      <= '0;
            data_q      <= '0;
            rs1_q       <= '0;
            rbuf_q      <= '0;
            idx_q       <= '0;
            wr_q        <= 1'b0;
            skip_q      <= 1'b0;
            fault_q     <= 1'b0;
            re_d1       <= 1'b0;
            sp_q        <= SP_W'(MEM_BYTES);
            busy        <= 1'b0;
            done        <= 1'b0;
            stack_fault <= 1'b0;
            mem_we      <= 1'b0;
            mem_re      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rdata       <= '0;
            ret_addr    <= '0;
            rs1_inc     <= '0;
        end else begin
            busy        <= busy_n;
            done        <= done_n;
            stack_fault <= fault_n;
            mem_we      <= we_n;
            mem_re      <= re_n;
            mem_addr    <= addr_n;
            mem_wdata   <= wd_n;
            re_d1       <= mem_re;
            if (state == XFER) idx_q <= idx_q + 2'd1;
            // Read bytes arrive one cycle after their strobe; shift in LSB first
            if (re_d1) rbuf_q <= {mem_rdata, rbuf_q[23:8]};
            if (accept) begin
                op_q    <= opcode;
                wr_q    <= is_wr;
                skip_q  <= !qual || fault_c;
                fault_q <= fault_c;
                rs1_q   <= rs1;
                idx_q   <= '0;
                data_q  <= (opcode == OP_CALL) ? pc + 32'd1 : wdata;
                if (is_push)     base_q <= ADDR_W'(sp_q - SP_W'(4));
                else if (is_pop) base_q <= ADDR_W'(sp_q);
                else             base_q <= address[ADDR_W-1:0];
                if (is_push && !fault_c) sp_q <= sp_q - SP_W'(4);
            end
            // Byte 3 is still on mem_rdata during DONE
            if ((state == DONE) && !skip_q) begin
                case (op_q)
                    OP_LW:    rdata <= {mem_rdata, rbuf_q};
                    OP_LWPOI: begin rdata <= {mem_rdata, rbuf_q}; rs1_inc <= rs1_q + 32'd1; end
                    OP_POP:   begin rdata <= {mem_rdata, rbuf_q}; sp_q <= sp_q + SP_W'(4); end
                    OP_RET:   begin ret_addr <= {mem_rdata, rbuf_q}; sp_q <= sp_q + SP_W'(4); end
                    default:  ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_stack_master.sv
// Randomized self-checking bench for mem_stack_master with a word-level memory/stack model.
`timescale 1ns/1ps
module tb_mem_stack_master;
    localparam int unsigned ADDR_W      = 10;
    localparam int unsigned MEM_BYTES   = 1024;
    localparam int unsigned STACK_LIMIT = 768;
    localparam int          MASK        = (1 << ADDR_W) - 1;

    localparam logic [5:0] OP_LW    = 6'b000101;
    localparam logic [5:0] OP_LWPOI = 6'b000110;
    localparam logic [5:0] OP_SW    = 6'b000111;
    localparam logic [5:0] OP_PUSH  = 6'b001111;
    localparam logic [5:0] OP_POP   = 6'b010000;
    localparam logic [5:0] OP_CALL  = 6'b001101;
    localparam logic [5:0] OP_RET   = 6'b001110;

    logic clk = 1'b0;
    logic rst_n, start, mem_read, mem_write;
    logic [5:0] opcode;
    logic [31:0] address, wdata, pc, rs1;
    logic busy, done, stack_fault, mem_we, mem_re;
    logic [31:0] rdata, ret_addr, rs1_inc;
    logic [ADDR_W-1:0] sp, mem_addr;
    logic [7:0] mem_wdata, mem_rdata;

    mem_stack_master #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES), .STACK_LIMIT(STACK_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .mem_read(mem_read), .mem_write(mem_write), .address(address),
        .wdata(wdata), .pc(pc), .rs1(rs1), .busy(busy), .done(done),
        .rdata(rdata), .ret_addr(ret_addr), .rs1_inc(rs1_inc), .sp(sp),
        .stack_fault(stack_fault), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int overlap = 0;
    logic [7:0] tmem [MEM_BYTES];
    int wr_addr_q[$];
    int wr_data_q[$];
    int wr_cyc_q[$];
    int rd_addr_q[$];
    int rd_cyc_q[$];

    // Reference model state
    logic [7:0] ref_mem [MEM_BYTES];
    int ref_sp;
    logic [31:0] exp_rdata, exp_ret, exp_rs1;

    // Byte memory (cleared by reset) plus strobe monitor
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_BYTES; i++) tmem[i] <= 8'h00;
            mem_rdata <= 8'h00;
        end else begin
            cyc = cyc + 1;
            if (mem_we && mem_re) overlap = overlap + 1;
            if (mem_we) begin
                tmem[mem_addr] <= mem_wdata;
                wr_addr_q.push_back(int'(mem_addr));
                wr_data_q.push_back(int'(mem_wdata));
                wr_cyc_q.push_back(cyc);
            end
            if (mem_re) begin
                mem_rdata <= tmem[mem_addr];
                rd_addr_q.push_back(int'(mem_addr));
                rd_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
        ref_sp    = MEM_BYTES;
        exp_rdata = '0;
        exp_ret   = '0;
        exp_rs1   = '0;
    endtask

    task automatic clear_logs();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        rd_addr_q.delete(); rd_cyc_q.delete();
    endtask

    task automatic do_reset();
        start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Issue one command, predict its effect at word level and compare everything observable
    task automatic exec_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] w,
                           input logic [31:0] p, input logic [31:0] r, input logic q, input bit inj);
        bit wr, flt, skip;
        int base, lat, exp_lat, t0;
        logic [31:0] d, v;
        int ea[$];
        int ed[$];
        wr  = (op == OP_SW) || (op == OP_PUSH) || (op == OP_CALL);
        flt = 1'b0;
`ifdef MEM_STACK_CHECK_EN
        if ((op == OP_PUSH || op == OP_CALL) && ref_sp < int'(STACK_LIMIT) + 4) flt = 1'b1;
        if ((op == OP_POP || op == OP_RET) && ref_sp >= int'(MEM_BYTES)) flt = 1'b1;
`endif
        skip = flt || (!q && (op == OP_LW || op == OP_LWPOI || op == OP_SW));
        if (op == OP_PUSH || op == OP_CALL)    base = ref_sp - 4;
        else if (op == OP_POP || op == OP_RET) base = ref_sp;
        else                                   base = int'(a[ADDR_W-1:0]);
        d = (op == OP_CALL) ? p + 32'd1 : w;
        v = '0;
        if (!skip) begin
            for (int i = 0; i < 4; i++) begin
                ea.push_back((base + i) & MASK);
                if (wr) begin
                    ed.push_back(int'(d[8*i +: 8]));
                    ref_mem[(base + i) & MASK] = d[8*i +: 8];
                end else begin
                    v[8*i +: 8] = ref_mem[(base + i) & MASK];
                end
            end
            if (op == OP_PUSH || op == OP_CALL) ref_sp = ref_sp - 4;
            if (op == OP_POP || op == OP_RET)   ref_sp = ref_sp + 4;
            if (op == OP_LW || op == OP_LWPOI || op == OP_POP) exp_rdata = v;
            if (op == OP_RET)   exp_ret = v;
            if (op == OP_LWPOI) exp_rs1 = r + 32'd1;
        end
        exp_lat = skip ? 1 : (wr ? 5 : 6);

        @(negedge clk);
        clear_logs();
        start = 1'b1; opcode = op; address = a; wdata = w; pc = p; rs1 = r;
        mem_read = q; mem_write = q;
        @(posedge clk); #1;
        t0 = cyc;
        start = 1'b0;
        lat = 0;
        check("busy_after_accept", busy, 1);
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (inj && lat == 1) begin start = 1'b1; opcode = OP_PUSH; end
            else if (inj && lat == 2) start = 1'b0;
        end
        check("latency", lat, exp_lat);
        check("busy_at_done", busy, 0);
        check("stack_fault", stack_fault, flt);
        check("rdata", rdata, exp_rdata);
        check("ret_addr", ret_addr, exp_ret);
        check("rs1_inc", rs1_inc, exp_rs1);
        check("sp", sp, ref_sp & MASK);
        @(posedge clk); #1;
        check("done_pulse", done, 0);
        check("wr_count", wr_addr_q.size(), wr ? ea.size() : 0);
        check("rd_count", rd_addr_q.size(), wr ? 0 : ea.size());
        for (int i = 0; i < ea.size(); i++) begin
            if (wr && i < wr_addr_q.size()) begin
                check($sformatf("wr_addr%0d", i), wr_addr_q[i], ea[i]);
                check($sformatf("wr_data%0d", i), wr_data_q[i], ed[i]);
                check($sformatf("wr_cyc%0d", i), wr_cyc_q[i], t0 + 2 + i);
            end
            if (!wr && i < rd_addr_q.size()) begin
                check($sformatf("rd_addr%0d", i), rd_addr_q[i], ea[i]);
                check($sformatf("rd_cyc%0d", i), rd_cyc_q[i], t0 + 2 + i);
            end
        end
    endtask

    initial begin
        logic [5:0] ops [7];
        ops = '{OP_LW, OP_LWPOI, OP_SW, OP_PUSH, OP_POP, OP_CALL, OP_RET};
        rst_n = 1'b1; start = 1'b0; opcode = '0; mem_read = 1'b0; mem_write = 1'b0;
        address = '0; wdata = '0; pc = '0; rs1 = '0;
        #1;
        do_reset();
        check("rst_sp", sp, MEM_BYTES & MASK);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_we", mem_we, 0);
        check("rst_re", mem_re, 0);
        check("rst_rdata", rdata, 0);
        check("rst_fault", stack_fault, 0);

        exec_op(OP_SW, 32'h10, 32'hA1B2C3D4, 0, 0, 1'b1, 1'b0);
        exec_op(OP_LW, 32'h10, 0, 0, 0, 1'b1, 1'b0);
        check("lw_word", rdata, 32'hA1B2C3D4);
        exec_op(OP_PUSH, 0, 32'h11223344, 0, 0, 1'b1, 1'b0);
        check("push_sp", sp, 1020);
        check("push_byte0", tmem[1020], 8'h44);
        exec_op(OP_POP, 0, 0, 0, 0, 1'b1, 1'b0);
        check("pop_word", rdata, 32'h11223344);
        exec_op(OP_CALL, 0, 0, 32'h40, 0, 1'b1, 1'b0);
        check("call_bytes", {tmem[1023], tmem[1022], tmem[1021], tmem[1020]}, 32'h41);
        exec_op(OP_RET, 0, 0, 0, 0, 1'b1, 1'b0);
        check("ret_word", ret_addr, 32'h41);
        exec_op(OP_LWPOI, 32'h3FE, 0, 0, 7, 1'b1, 1'b0);
        check("poi_inc", rs1_inc, 8);
        exec_op(OP_LW, 32'h10, 0, 0, 0, 1'b0, 1'b0);
        exec_op(OP_SW, 32'h200, 32'hDEADBEEF, 0, 0, 1'b0, 1'b0);
        exec_op(OP_SW, 32'h20, 32'h5A5AA5A5, 0, 0, 1'b1, 1'b1);

        // Illegal opcode must not be accepted
        @(negedge clk);
        clear_logs();
        start = 1'b1; opcode = 6'h3F;
        @(posedge clk); #1;
        start = 1'b0;
        check("illegal_busy", busy, 0);
        repeat (6) @(posedge clk);
        #1;
        check("illegal_done", done, 0);
        check("illegal_strobes", wr_addr_q.size() + rd_addr_q.size(), 0);

`ifdef MEM_STACK_CHECK_EN
        do_reset();
        exec_op(OP_POP, 0, 0, 0, 0, 1'b1, 1'b0);
        check("underflow_sp", sp, MEM_BYTES & MASK);
        for (int i = 0; i < 64; i++) exec_op(OP_PUSH, 0, $urandom, 0, 0, 1'b1, 1'b0);
        exec_op(OP_PUSH, 0, 32'hFFFF0000, 0, 0, 1'b1, 1'b0);
        check("overflow_sp", sp, 768);
`endif

        do_reset();
        for (int n = 0; n < 150; n++) begin
            exec_op(ops[$urandom_range(0, 6)], $urandom, $urandom, $urandom, $urandom,
                    logic'($urandom_range(0, 3) != 0), 1'b0);
        end

        // Abort a PUSH while byte 1 is on the bus
        do_reset();
        @(negedge clk);
        start = 1'b1; opcode = OP_PUSH; wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("abort_pre_we", mem_we, 1);
        check("abort_pre_addr", mem_addr, 1021);
        check("abort_pre_sp", sp, 1020);
        rst_n = 1'b0;
        #1;
        check("abort_we", mem_we, 0);
        check("abort_sp", sp, MEM_BYTES & MASK);
        check("abort_busy", busy, 0);
        check("abort_addr", mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        exec_op(OP_PUSH, 0, 32'h0BADF00D, 0, 0, 1'b1, 1'b0);
        exec_op(OP_POP, 0, 0, 0, 0, 1'b1, 1'b0);

        check("we_re_overlap", overlap, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
